usbfs_debug_uart_rx: RTL and testbench

- Receives 8N1 UART bytes on the debug serial line and buffers them in a FIFO of 2^ASIZE bytes.
- Presents buffered bytes to the USB-side logic through a valid/enable handshake.
- It is the receive-direction counterpart of the debug UART transmit path.
- Typical use: host-injected debug commands and loopback checks of the debug channel.

---
 rtl/usbfs_debug_pkg.sv | 17 +
 rtl/usbfs_debug_fifo.sv | 64 ++++++
 rtl/usbfs_debug_uart_rx.sv | 157 +++++++++++++++
 tb/tb_usbfs_debug_uart_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_debug_pkg.sv
// Shared definitions for the USB full-speed debug UART paths.
package usbfs_debug_pkg;

    localparam int unsigned DEFAULT_CLK_DIV = 434;  // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_ASIZE   = 4;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BIT_IDX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/usbfs_debug_fifo.sv
// First-word-fall-through byte FIFO; the array has no reset and a registered
// read port so it can map onto block RAM.
module usbfs_debug_fifo
    import usbfs_debug_pkg::*;
#(
    parameter int unsigned ASIZE = DEFAULT_ASIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] push_data_i,
    output logic              drop_c_o,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [BYTE_W-1:0] data_o
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PTR_W = ASIZE + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] data_q;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic              valid_q;
    logic              full_c;
    logic              pop_c;
    logic              wr_c;

    // A pop in the same cycle frees a slot, so full is judged after it.
    always_comb begin
        full_c   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                   (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
        pop_c    = pop_i & valid_q;
        wr_c     = push_i & (~full_c | pop_c);
        drop_c_o = push_i & full_c & ~pop_c;
        wptr_d   = wptr_q + PTR_W'(wr_c);
        rptr_d   = rptr_q + PTR_W'(pop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            // Compare against the pre-write pointer: the entry must already be in the array.
            valid_q <= (wptr_q != rptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wptr_q[ASIZE-1:0]] <= push_data_i;
        end
        data_q <= mem_q[rptr_d[ASIZE-1:0]];
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/usbfs_debug_uart_rx.sv
// 8N1 debug UART receiver: oversampling FSM feeding a FWFT byte FIFO toward
// the USB-side consumer.
module usbfs_debug_uart_rx
    import usbfs_debug_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned ASIZE   = DEFAULT_ASIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_en,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BYTE_W - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d;
    logic [1:0]           sync_q;
    logic [1:0]           fill_q;
    logic                 armed_q, armed_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_drop_c;
    logic                 rxs;

    assign rxs = sync_q[1];

    // Synchronizer plus a fill marker that says when rxs reflects the real line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            fill_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            armed_q     <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            armed_q     <= armed_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // A line held low through reset must go high once before a start bit counts.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        armed_d     = armed_q | (rxs & fill_q[1]);
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = fifo_drop_c;

        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && !rxs) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[BYTE_W-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    usbfs_debug_fifo #(
        .ASIZE(ASIZE)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_q),
        .push_data_i(shreg_q),
        .drop_c_o   (fifo_drop_c),
        .pop_i      (rx_en),
        .valid_o    (rx_valid),
        .data_o     (rx_data)
    );

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_usbfs_debug_uart_rx.sv
// Bench for usbfs_debug_uart_rx: directed scenarios plus random frames checked
// against a queue-based model of the receive FIFO.
module tb_usbfs_debug_uart_rx;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned ASIZE   = 2;
    localparam int unsigned DEPTH   = 1 << ASIZE;
    localparam int unsigned EARLY   = CLK_DIV / 2 + 2;

    logic       clk;
    logic       rst;
    logic       i_uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_en;
    logic       frame_err;
    logic       overflow;

    int n_cmp;
    int n_err;
    int ferr_seen;
    int ovf_seen;
    int exp_ferr;
    int exp_ovf;
    logic [7:0] exp_q[$];

    usbfs_debug_uart_rx #(
        .CLK_DIV(CLK_DIV),
        .ASIZE  (ASIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_uart_rx(i_uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_en    (rx_en),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every high cycle counts, so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_seen <= ferr_seen + 1;
            if (overflow)  ovf_seen  <= ovf_seen + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame starting at the current negedge; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles);
        for (int i = 0; i < 9; i++) begin
            i_uart_rx = (i == 0) ? 1'b0 : b[i-1];
            repeat (CLK_DIV) @(negedge clk);
        end
        i_uart_rx = stop;
        repeat (stop_cycles) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_ferr++;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic [7:0] exp_b;
        n = 0;
        while (!rx_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
        exp_b = exp_q.pop_front();
        check_eq({tag, "_data"}, 32'(rx_data), 32'(exp_b));
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        @(negedge clk);
        check_eq({tag, "_empty"}, 32'(rx_valid), 32'd0);
    endtask

    task automatic check_events(input string tag);
        check_eq({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
        check_eq({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        int         scyc;
        int         npop;
        logic [7:0] partial;

        n_cmp = 0; n_err = 0; ferr_seen = 0; ovf_seen = 0;
        exp_ferr = 0; exp_ovf = 0;
        rst = 1'b1; i_uart_rx = 1'b1; rx_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with latency window around the nominal ~80 cycles.
        fork
            send_frame(8'h5A, 1'b1, CLK_DIV);
            begin
                repeat (77) @(negedge clk);
                check_eq("t1_not_early", 32'(rx_valid), 32'd0);
                repeat (5) @(negedge clk);
                check_eq("t1_latency", 32'(rx_valid), 32'd1);
            end
        join
        model_frame(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        check_events("t1");
        drain_check("t1");

        // Glitch rejection.
        i_uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t2_glitch", 32'(rx_valid), 32'd0);
        send_frame(8'hA5, 1'b1, CLK_DIV);
        model_frame(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        check_events("t2");
        drain_check("t2");

        // Overflow, with early start bits between frames.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, (k < 5) ? EARLY : CLK_DIV);
            model_frame(8'(k), 1'b1);
        end
        repeat (3) @(negedge clk);
        check_events("t3");
        drain_check("t3");

        // Framing error followed by a long break.
        send_frame(8'hFF, 1'b0, CLK_DIV);
        model_frame(8'hFF, 1'b0);
        repeat (30 * CLK_DIV) @(negedge clk);
        i_uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check_events("t4");
        check_eq("t4_no_byte", 32'(rx_valid), 32'd0);
        send_frame(8'h3C, 1'b1, CLK_DIV);
        model_frame(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        drain_check("t4");

        // Full FIFO with a pop on the exact write cycle of the next byte.
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1, CLK_DIV);
            model_frame(8'(k), 1'b1);
        end
        repeat (3) @(negedge clk);
        fork
            send_frame(8'h77, 1'b1, CLK_DIV);
            begin
                repeat (79) @(negedge clk);
                check_eq("t5_head", 32'(rx_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                rx_en = 1'b1;
                @(negedge clk);
                rx_en = 1'b0;
            end
        join
        model_frame(8'h77, 1'b1);
        repeat (3) @(negedge clk);
        check_events("t5");
        drain_check("t5");

        // Reset in the middle of data bit 4.
        send_frame(8'h11, 1'b1, CLK_DIV);
        model_frame(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("t6_pre", 32'(rx_valid), 32'd1);
        partial = 8'h99;
        i_uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            i_uart_rx = partial[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        i_uart_rx = partial[4];
        repeat (CLK_DIV / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(rx_valid), 32'd0);
        exp_q.delete();
        i_uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t6_post", 32'(rx_valid), 32'd0);
        send_frame(8'h42, 1'b1, CLK_DIV);
        model_frame(8'h42, 1'b1);
        repeat (3) @(negedge clk);
        check_events("t6");
        drain_check("t6");

        // Random frames, stop lengths, framing errors and pops.
        for (int it = 0; it < 40; it++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            scyc = ($urandom_range(0, 1) == 0) ? CLK_DIV : EARLY;
            if (good) begin
                send_frame(b, 1'b1, scyc);
            end else begin
                send_frame(b, 1'b0, CLK_DIV);
                repeat ($urandom_range(0, 2) * CLK_DIV) @(negedge clk);
                i_uart_rx = 1'b1;
                repeat (CLK_DIV) @(negedge clk);
            end
            model_frame(b, good);
            repeat (3) @(negedge clk);
            check_events("rnd");
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                if (exp_q.size() > 0) pop_check("rnd");
            end
        end
        drain_check("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
